// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between two writeback
//   requesters (A = ALU, B = load return). Round-robin arbitration with
//   a valid/ready handshake per requester, a registered write port with
//   1-cycle latency, and a pending-write scoreboard that decode queries
//   to stall on RAW hazards.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   a_valid/a_rd/a_data requester A request; a_ready = A granted this cycle
//   b_valid/b_rd/b_data requester B request; b_ready = B granted this cycle
//   issue_valid/issue_rd decode marks issue_rd as having a write in flight
//   flush               clears the scoreboard (write port unaffected)
//   chk_rs1/chk_rs2     decode source queries; stall if either is pending
//   regwrite/rd/write_data  registered write port to the regfile
module regfile_wb_arbiter #(
  parameter  int REG_COUNT = 32,
  parameter  int XLEN      = 32,
  localparam int IW        = $clog2(REG_COUNT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [IW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [IW-1:0]   b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  input  logic            issue_valid,
  input  logic [IW-1:0]   issue_rd,
  input  logic            flush,
  input  logic [IW-1:0]   chk_rs1,
  input  logic [IW-1:0]   chk_rs2,
  output logic            stall,
  output logic            regwrite,
  output logic [IW-1:0]   rd,
  output logic [XLEN-1:0] write_data
);

  typedef struct packed {
    logic            valid;
    logic [IW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  logic                 last_b;   // 1: B won the most recent transfer
  logic [REG_COUNT-1:0] pending;
  logic [REG_COUNT-1:0] pending_nxt;
  wb_req_t              gnt;
  logic                 xfer;

  // Ready depends only on valids, last_b and rst -- never on rd/data.
  // Gating with rst keeps both requesters stalled during reset.
  assign a_ready = rst & a_valid & (~b_valid | last_b);
  assign b_ready = rst & b_valid & (~a_valid | ~last_b);
  assign xfer    = a_ready | b_ready;

  always_comb begin
    gnt = '0;
    if (a_ready)      gnt = '{valid: 1'b1, rd: a_rd, data: a_data};
    else if (b_ready) gnt = '{valid: 1'b1, rd: b_rd, data: b_data};
  end

  // Scoreboard next state. Issue is applied after the transfer clear so a
  // same-register issue/writeback at one edge leaves the newer producer
  // outstanding. Flush wipes everything, including that edge's issue.
  always_comb begin
    pending_nxt = pending;
    if (flush) begin
      pending_nxt = '0;
    end else begin
      if (gnt.valid)                    pending_nxt[gnt.rd]   = 1'b0;
      if (issue_valid && issue_rd != '0) pending_nxt[issue_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      regwrite   <= 1'b0;
      rd         <= '0;
      write_data <= '0;
      last_b     <= 1'b1;
      pending    <= '0;
    end else begin
      // x0 writes consume the grant but never reach the regfile.
      regwrite <= gnt.valid && (gnt.rd != '0);
      if (xfer) begin
        rd         <= gnt.rd;
        write_data <= gnt.data;
        last_b     <= b_ready;
      end
      pending <= pending_nxt;
    end
  end

  // No bypass of an incoming transfer: the bit drops when regwrite is
  // presented, one cycle after the grant edge.
  assign stall = ((chk_rs1 != '0) && pending[chk_rs1]) ||
                 ((chk_rs2 != '0) && pending[chk_rs2]);

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (regwrite/rd/write_data) between two writeback requesters: A (ALU writeback) and B (load/memory return).
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Keeps a pending-write scoreboard so decode can stall on RAW hazards against registers not yet written.
- Sits between the pipeline writeback stages and regfile.

Parameters:
REG_COUNT, 32, number of architectural registers; index width is $clog2(REG_COUNT)
XLEN, 32, data width of write_data and requester data

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-low: state clears on a rising clk edge while rst==0
a_valid  input  1  requester A has a write pending
a_rd  input  $clog2(REG_COUNT)  requester A destination register
a_data  input  XLEN  requester A write data
a_ready  output  1  requester A granted this cycle
b_valid  input  1  requester B has a write pending
b_rd  input  $clog2(REG_COUNT)  requester B destination register
b_data  input  XLEN  requester B write data
b_ready  output  1  requester B granted this cycle
issue_valid  input  1  decode issues an instruction that will write issue_rd
issue_rd  input  $clog2(REG_COUNT)  destination register of the issued instruction
flush  input  1  pipeline flush; clears the scoreboard
chk_rs1  input  $clog2(REG_COUNT)  decode source register 1 query
chk_rs2  input  $clog2(REG_COUNT)  decode source register 2 query
stall  output  1  chk_rs1 or chk_rs2 has a pending write
regwrite  output  1  registered write enable to regfile
rd  output  $clog2(REG_COUNT)  registered write address to regfile
write_data  output  XLEN  registered write data to regfile

Behaviour:
- Reset (rst==0 at a clk edge):
  - regwrite=0, rd=0, write_data=0.
  - pending[REG_COUNT-1:0]=0.
  - last_grant=B, so A wins the first contention.
  - stall follows pending and is therefore 0.
- Handshake:
  - A transfer occurs when x_valid && x_ready at a clk edge.
  - A requester holds valid/rd/data stable until ready is seen.
  - Ready is combinational from valid and last_grant. No combinational path from rd/data to ready.
  - a_ready and b_ready are never both 1.
- Arbitration:
  - Only A valid -> grant A.
  - Only B valid -> grant B.
  - Both valid -> grant the requester not equal to last_grant.
  - last_grant updates to the granted requester on every transfer; it holds when there is no transfer.
  - Back-to-back contention therefore alternates A, B, A, B.
- Write port:
  - Latency is 1 cycle. On a transfer edge: rd <= granted rd, write_data <= granted data, regwrite <= (granted rd != 0).
  - With no transfer: regwrite <= 0, and rd/write_data hold their previous values.
  - rd==0 requests are accepted and consume the grant (last_grant updates), but regwrite stays 0.
- Scoreboard:
  - Issue: issue_valid && issue_rd!=0 sets pending[issue_rd].
  - Transfer: clears pending[granted rd].
  - Set and clear of the same register at the same edge -> set wins (the newer producer is outstanding).
  - pending[0] is always 0.
  - flush=1 clears all bits and ignores issue_valid at that edge. Arbitration and the write port are unaffected by flush.
- stall:
  - stall = (chk_rs!=0 && pending[chk_rs]) for either source register.
  - Purely combinational from the pending register and chk_rs1/chk_rs2; no same-cycle bypass of incoming transfers.
  - The bit drops the cycle after the grant edge, aligned with regwrite being presented to regfile.
- Reset mid-operation:
  - Any grant in flight is dropped: regwrite=0 on the next cycle.
  - No ready is asserted while rst==0.
  - Requesters re-present after reset.

Test Plan:
1. Reset, then A only: a_valid=1, a_rd=5, a_data=A5A5A5A5 -> a_ready=1 that cycle; next cycle regwrite=1, rd=5, write_data=A5A5A5A5; following cycle regwrite=0.
2. Contention: A (rd=10, 12345678) and B (rd=15, 87654321) both held valid -> grants A then B on consecutive edges; regwrite writes x10 then x15; a_ready and b_ready never both high.
3. x0 write: B valid, b_rd=0, b_data=FFFFFFFF -> b_ready=1, regwrite stays 0, last_grant=B; next contention grants A.
4. Scoreboard: issue rd=7, then chk_rs1=7 -> stall=1; A writes rd=7 -> stall=0 from the cycle after the grant. Same-edge issue rd=7 plus grant rd=7 -> stall stays 1.
5. Flush: pending x3 and x9, assert flush with issue_valid=1, issue_rd=4 -> all pending clear; chk_rs1=4 and chk_rs2=9 give stall=0.
6. Reset mid-transfer: A valid rd=6 and rst=0 at the grant edge -> regwrite=0 next cycle, pending=0, a_ready=0 during reset.
